wrdata_align_pipe: RTL and testbench
====================================

WRDATA_ALIGN_PIPE -- requirements
Module: wrdata_align_pipe

Interface
REQ-001 The module SHALL have parameter LANES, default 1, giving the number of 20-bit lanes; legal values are 1, 2 and 4.
REQ-002 The module SHALL have parameter DATA_W, default 20*LANES, giving the datapath width; it is not overridden independently.
REQ-003 The module SHALL have parameter SEL_W, default $clog2(DATA_W), giving the slot-select width.
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The module SHALL have port rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port cfg_i, input, 3 bits: width config code (CONFIG_1BIT..CONFIG_80BIT).
REQ-007 The module SHALL have port bist_active_i, input, 1 bit: BIST access, which forces pass-through.
REQ-008 The module SHALL have port valid_i, input, 1 bit: input beat valid.
REQ-009 The module SHALL have port ready_o, output, 1 bit: input beat accepted.
REQ-010 The module SHALL have port slot_i, input, SEL_W bits: target slot (low address bits).
REQ-011 The module SHALL have ports wrdata_i and bitmask_i, input, DATA_W bits each: raw write data and raw mask.
REQ-012 The module SHALL have port valid_o, output, 1 bit: output beat valid.
REQ-013 The module SHALL have port ready_i, input, 1 bit: downstream ready.
REQ-014 The module SHALL have ports wrdata_o and bitmask_o, output, DATA_W bits each: aligned data and mask.
REQ-015 The module SHALL have port cfg_pend_o, output, 1 bit: high while a cfg_i change is waiting to be applied.
REQ-016 The module SHALL have port err_o, output, 1 bit: sticky error flag.
REQ-017 The module SHALL have port err_clr_i, input, 1 bit: clears err_o.

Function
REQ-018 Width w of a config code SHALL be: 1BIT=1, 2BIT=2, 5BIT=5, 10BIT=10, 20BIT=20, 40BIT=40, 80BIT=80.
REQ-019 The active config cfg_q SHALL update from cfg_i only in a cycle with valid_o=0 and valid_i=0; otherwise, when cfg_i differs from cfg_q, cfg_pend_o=1.
REQ-020 A beat SHALL transfer in when valid_i and ready_o are both high, with ready_o = !valid_o || ready_i (one-entry pipe register, 1-cycle latency).
REQ-021 A beat SHALL transfer out when valid_o and ready_i are both high; simultaneous in and out transfers SHALL reload the register without a bubble.
REQ-022 The output register SHALL hold its contents stable while valid_o=1 and ready_i=0.
REQ-023 Pass-through mode SHALL apply when bist_active_i=1 or w>=DATA_W: wrdata_o=wrdata_i and bitmask_o=bitmask_i, both registered.
REQ-024 Aligned mode SHALL apply when w<DATA_W: wrdata_o replicates wrdata_i[w-1:0] across all DATA_W/w slots.
REQ-025 In aligned mode, bitmask_o bits [slot_i*w +: w] SHALL equal bitmask_i[w-1:0] and all other bitmask_o bits SHALL be 0.
REQ-026 In aligned mode with slot_i >= DATA_W/w, the beat SHALL be forwarded with bitmask_o all zeros and err_o SHALL be set.
REQ-027 When cfg_q is an illegal code (3'd0), any beat SHALL be forwarded with bitmask_o all zeros and err_o SHALL be set.
REQ-028 bist_active_i SHALL be sampled with the beat on each accepted transfer, not via cfg_q.
REQ-029 err_o SHALL remain set until err_clr_i=1; if err_clr_i and a new error occur in the same cycle, err_o SHALL stay set.

Reset
REQ-030 While rstn_i=0, asynchronously: valid_o=0, wrdata_o=0, bitmask_o=0, err_o=0, cfg_pend_o=0.
REQ-031 While rstn_i=0, asynchronously: cfg_q=CONFIG_20BIT.
REQ-032 Reset asserted mid-transfer SHALL drop the in-flight beat; the first beat after reset deassertion SHALL be accepted in the first clock with valid_i=1.

Structure
REQ-033 The CONFIG_* codes, a width-lookup function cfg_width(code) and the illegal-code constant SHALL live in a shared package, ram_cfg_pkg.
REQ-034 The slot/mask placement SHALL be one combinational sub-module, slot_align (parameters DATA_W, SEL_W), instantiated once ahead of the pipe register.

Verification
REQ-035 LANES=1, cfg=5BIT, slot_i=3, wrdata_i[4:0]=5'h15, bitmask_i[4:0]=5'h1F -> next cycle wrdata_o=20'hAD6B5, bitmask_o=20'hF8000, valid_o=1.
REQ-036 LANES=2, cfg=20BIT, slot_i=1, mask=20'hFFFFF -> bitmask_o=40'hFFFFF00000; the same beat with bist_active_i=1 -> bitmask_o=raw bitmask_i.
REQ-037 LANES=1, cfg=10BIT, slot_i=2 -> bitmask_o=0 and err_o=1; err_clr_i pulse -> err_o=0 the next cycle.
REQ-038 Hold ready_i=0 for 5 cycles with valid_i=1 -> outputs stable and ready_o=0; release ready_i -> back-to-back beats at one per cycle, none lost or duplicated.
REQ-039 Change cfg_i while valid_o=1 -> cfg_pend_o=1 and the old alignment is kept; after the pipe drains and one idle cycle -> cfg_pend_o=0 and the new alignment applies.
REQ-040 Assert rstn_i low between accept and emit -> valid_o=0 immediately, the beat is never emitted, and cfg_q=20BIT.

Source files
------------

// File: rtl/ram_cfg_pkg.sv
// Shared width-configuration codes and helpers for the write-data alignment path.
package ram_cfg_pkg;

    // Width configuration codes; code 0 is reserved as the illegal setting.
    typedef enum logic [2:0] {
        CONFIG_ILLEGAL = 3'd0,
        CONFIG_1BIT    = 3'd1,
        CONFIG_2BIT    = 3'd2,
        CONFIG_5BIT    = 3'd3,
        CONFIG_10BIT   = 3'd4,
        CONFIG_20BIT   = 3'd5,
        CONFIG_40BIT   = 3'd6,
        CONFIG_80BIT   = 3'd7
    } cfg_code_e;

    localparam logic [2:0] CFG_ILLEGAL_CODE = 3'd0;
    localparam int         CFG_NUM_CODES    = 8;

    // Bit width selected by a configuration code (0 for the illegal code).
    function automatic int cfg_width(input logic [2:0] code);
        case (code)
            CONFIG_1BIT:  return 1;
            CONFIG_2BIT:  return 2;
            CONFIG_5BIT:  return 5;
            CONFIG_10BIT: return 10;
            CONFIG_20BIT: return 20;
            CONFIG_40BIT: return 40;
            CONFIG_80BIT: return 80;
            default:      return 0;
        endcase
    endfunction

endpackage

// File: rtl/slot_align.sv
// Combinational slot placement: replicates narrow write data across the bus
// and steers the narrow mask into the addressed slot.
module slot_align
    import ram_cfg_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int SEL_W  = $clog2(DATA_W)
) (
    input  logic [2:0]        i_cfg,
    input  logic              i_bist,
    input  logic [SEL_W-1:0]  i_slot,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic [DATA_W-1:0] i_bitmask,
    output logic [DATA_W-1:0] o_wrdata,
    output logic [DATA_W-1:0] o_bitmask,
    output logic              o_err
);

    logic [CFG_NUM_CODES-1:0][DATA_W-1:0] w_repData;
    logic [CFG_NUM_CODES-1:0][DATA_W-1:0] w_placedMask;
    logic [CFG_NUM_CODES-1:0]             w_slotInRange;
    logic [CFG_NUM_CODES-1:0]             w_narrow;

    assign w_repData[0]     = '0;
    assign w_placedMask[0]  = '0;
    assign w_slotInRange[0] = 1'b0;
    assign w_narrow[0]      = 1'b0;

    // One fixed-width candidate per legal code; the active one is picked below.
    for (genvar g = 1; g < CFG_NUM_CODES; g++) begin : gWidth
        localparam int W     = cfg_width(3'(g));
        localparam int SLOTS = DATA_W / W;

        logic [DATA_W-1:0] w_rep;
        logic [DATA_W-1:0] w_mask;

        // Bit i takes data bit i mod W; mask bit i is live only inside the addressed slot.
        always_comb begin
            w_rep  = '0;
            w_mask = '0;
            for (int i = 0; i < DATA_W; i++) begin
                w_rep[i]  = i_wrdata[i % W];
                w_mask[i] = (32'(i_slot) == 32'(i / W)) ? i_bitmask[i % W] : 1'b0;
            end
        end

        assign w_repData[g]     = w_rep;
        assign w_placedMask[g]  = w_mask;
        assign w_slotInRange[g] = (32'(i_slot) < 32'(SLOTS));
        assign w_narrow[g]      = (W < DATA_W);
    end

    // Illegal code kills the mask; BIST or full-width codes pass straight through.
    always_comb begin
        o_wrdata  = i_wrdata;
        o_bitmask = i_bitmask;
        o_err     = 1'b0;
        if (i_cfg == CFG_ILLEGAL_CODE) begin
            o_bitmask = '0;
            o_err     = 1'b1;
        end else if (!i_bist && w_narrow[i_cfg]) begin
            o_wrdata = w_repData[i_cfg];
            if (w_slotInRange[i_cfg]) begin
                o_bitmask = w_placedMask[i_cfg];
            end else begin
                o_bitmask = '0;
                o_err     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrdata_align_pipe.sv
// Write-data alignment stage: slot placement followed by a one-entry
// valid/ready pipe register, with a safely-applied width configuration.
module wrdata_align_pipe
    import ram_cfg_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int DATA_W = 20 * LANES,
    parameter int SEL_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [2:0]        cfg_i,
    input  logic              bist_active_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [SEL_W-1:0]  slot_i,
    input  logic [DATA_W-1:0] wrdata_i,
    input  logic [DATA_W-1:0] bitmask_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] wrdata_o,
    output logic [DATA_W-1:0] bitmask_o,
    output logic              cfg_pend_o,
    output logic              err_o,
    input  logic              err_clr_i
);

    logic              r_valid;
    logic [DATA_W-1:0] r_wrdata;
    logic [DATA_W-1:0] r_bitmask;
    logic              r_err;
    logic [2:0]        r_cfgQ;
    logic              r_cfgPend;

    logic              w_accept;
    logic              w_cfgIdle;
    logic [DATA_W-1:0] w_alignData;
    logic [DATA_W-1:0] w_alignMask;
    logic              w_alignErr;

    assign ready_o   = !r_valid || ready_i;
    assign w_accept  = valid_i && ready_o;
    assign w_cfgIdle = !r_valid && !valid_i;

    slot_align #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_slotAlign (
        .i_cfg     (r_cfgQ),
        .i_bist    (bist_active_i),
        .i_slot    (slot_i),
        .i_wrdata  (wrdata_i),
        .i_bitmask (bitmask_i),
        .o_wrdata  (w_alignData),
        .o_bitmask (w_alignMask),
        .o_err     (w_alignErr)
    );

    // Pipe register: load on accept (also covers reload-while-emitting), empty on drain.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_valid   <= 1'b0;
            r_wrdata  <= '0;
            r_bitmask <= '0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_wrdata  <= w_alignData;
            r_bitmask <= w_alignMask;
        end else if (ready_i) begin
            r_valid   <= 1'b0;
        end
    end

    // Sticky error: a new error on an accepted beat wins over a clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_err <= 1'b0;
        end else if (w_accept && w_alignErr) begin
            r_err <= 1'b1;
        end else if (err_clr_i) begin
            r_err <= 1'b0;
        end
    end

    // Config only switches when nothing is in flight or arriving, so no beat mixes widths.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cfgQ    <= CONFIG_20BIT;
            r_cfgPend <= 1'b0;
        end else if (w_cfgIdle) begin
            r_cfgQ    <= cfg_i;
            r_cfgPend <= 1'b0;
        end else begin
            r_cfgPend <= (cfg_i != r_cfgQ);
        end
    end

    assign valid_o    = r_valid;
    assign wrdata_o   = r_wrdata;
    assign bitmask_o  = r_bitmask;
    assign err_o      = r_err;
    assign cfg_pend_o = r_cfgPend;

endmodule

// File: tb/tb_wrdata_align_pipe.sv
// Self-checking bench for wrdata_align_pipe: directed corner cases plus
// randomized traffic scored against a behavioural alignment model.
module tb_wrdata_align_pipe;

    localparam logic [2:0] C_ILL = 3'd0;
    localparam logic [2:0] C_2   = 3'd2;
    localparam logic [2:0] C_5   = 3'd3;
    localparam logic [2:0] C_10  = 3'd4;
    localparam logic [2:0] C_20  = 3'd5;

    // Free-running clock shared by both instances
    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    // Single-lane instance signals
    logic [2:0]  cfgIn;
    logic        bistIn, validIn, readyOut, validOut, readyIn, cfgPend, errOut, errClr;
    logic [4:0]  slotIn;
    logic [19:0] wrdataIn, bitmaskIn, wrdataOut, bitmaskOut;

    // Dual-lane instance signals
    logic [2:0]  bCfg;
    logic        bBist, bValid, bReadyOut, bValidOut, bReady, bPend, bErr, bClr;
    logic [5:0]  bSlot;
    logic [39:0] bData, bMask, bDataOut, bMaskOut;

    int checkCount = 0;
    int passCount  = 0;

    // Reference state for the single-lane instance
    logic        mValid, mErr, mPend;
    logic [2:0]  mCfgQ;
    logic [19:0] mData, mMask;

    // Reference state for the dual-lane instance
    logic        bErrExp;
    logic [2:0]  bCfgQ;

    wrdata_align_pipe #(.LANES(1)) dut1 (
        .clk_i(clk), .rstn_i(rstn), .cfg_i(cfgIn), .bist_active_i(bistIn),
        .valid_i(validIn), .ready_o(readyOut), .slot_i(slotIn),
        .wrdata_i(wrdataIn), .bitmask_i(bitmaskIn), .valid_o(validOut),
        .ready_i(readyIn), .wrdata_o(wrdataOut), .bitmask_o(bitmaskOut),
        .cfg_pend_o(cfgPend), .err_o(errOut), .err_clr_i(errClr)
    );

    wrdata_align_pipe #(.LANES(2)) dut2 (
        .clk_i(clk), .rstn_i(rstn), .cfg_i(bCfg), .bist_active_i(bBist),
        .valid_i(bValid), .ready_o(bReadyOut), .slot_i(bSlot),
        .wrdata_i(bData), .bitmask_i(bMask), .valid_o(bValidOut),
        .ready_i(bReady), .wrdata_o(bDataOut), .bitmask_o(bMaskOut),
        .cfg_pend_o(bPend), .err_o(bErr), .err_clr_i(bClr)
    );

    // Every comparison funnels through here so the counts stay honest
    task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    endtask

    // What a beat should look like on the output, straight from the width/slot rules
    function automatic void refAlign(input int dataW, input logic [2:0] cfg, input logic bistIn_,
                                     input int slot, input logic [79:0] d, input logic [79:0] m,
                                     output logic [79:0] ed, output logic [79:0] em, output logic eerr);
        int widths [8] = '{0, 1, 2, 5, 10, 20, 40, 80};
        int w;
        w    = widths[cfg];
        ed   = '0;
        em   = '0;
        eerr = 1'b0;
        if (cfg == 3'd0) begin
            for (int i = 0; i < dataW; i++) ed[i] = d[i];
            eerr = 1'b1;
        end else if (bistIn_ || w >= dataW) begin
            for (int i = 0; i < dataW; i++) begin
                ed[i] = d[i];
                em[i] = m[i];
            end
        end else begin
            for (int i = 0; i < dataW; i++) ed[i] = d[i % w];
            if (slot < dataW / w) begin
                for (int j = 0; j < w; j++) em[slot * w + j] = m[j];
            end else begin
                eerr = 1'b1;
            end
        end
    endfunction

    // Drive one cycle's worth of inputs on the single-lane instance
    task automatic applyStimulus(input logic vi, input logic ri, input logic [2:0] c, input logic b,
                                 input logic [4:0] s, input logic [19:0] d, input logic [19:0] m, input logic clr);
        validIn   = vi;
        readyIn   = ri;
        cfgIn     = c;
        bistIn    = b;
        slotIn    = s;
        wrdataIn  = d;
        bitmaskIn = m;
        errClr    = clr;
    endtask

    // One clock on the single-lane instance: drive, predict, then compare after the edge
    task automatic stepCycle(input logic vi, input logic ri, input logic [2:0] c, input logic b,
                             input logic [4:0] s, input logic [19:0] d, input logic [19:0] m, input logic clr);
        logic [79:0] ed, em;
        logic        eerr, acc, nValid, nErr, nPend;
        logic [2:0]  nCfg;
        logic [19:0] nData, nMask;
        applyStimulus(vi, ri, c, b, s, d, m, clr);
        #1;
        checkOutput("ready_o", readyOut, !mValid || ri);
        acc = vi && (!mValid || ri);
        refAlign(20, mCfgQ, b, int'(s), {60'b0, d}, {60'b0, m}, ed, em, eerr);
        nValid = mValid;
        nData  = mData;
        nMask  = mMask;
        if (acc) begin
            nValid = 1'b1;
            nData  = ed[19:0];
            nMask  = em[19:0];
        end else if (mValid && ri) begin
            nValid = 1'b0;
        end
        nErr = (acc && eerr) ? 1'b1 : (clr ? 1'b0 : mErr);
        if (!mValid && !vi) begin
            nCfg  = c;
            nPend = 1'b0;
        end else begin
            nCfg  = mCfgQ;
            nPend = (c != mCfgQ);
        end
        @(posedge clk);
        #1;
        mValid = nValid; mData = nData; mMask = nMask; mErr = nErr; mCfgQ = nCfg; mPend = nPend;
        checkOutput("valid_o", validOut, mValid);
        checkOutput("err_o", errOut, mErr);
        checkOutput("cfg_pend_o", cfgPend, mPend);
        if (mValid) begin
            checkOutput("wrdata_o", wrdataOut, mData);
            checkOutput("bitmask_o", bitmaskOut, mMask);
        end
        @(negedge clk);
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, release on a falling edge
    task automatic doReset();
        rstn = 1'b0;
        #1;
        checkOutput("rst valid_o", validOut, 1'b0);
        checkOutput("rst wrdata_o", wrdataOut, 20'h0);
        checkOutput("rst bitmask_o", bitmaskOut, 20'h0);
        checkOutput("rst err_o", errOut, 1'b0);
        checkOutput("rst cfg_pend_o", cfgPend, 1'b0);
        checkOutput("rst b valid_o", bValidOut, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rst valid_o held", validOut, 1'b0);
        @(negedge clk);
        rstn   = 1'b1;
        mValid = 1'b0; mErr = 1'b0; mPend = 1'b0; mCfgQ = C_20; mData = '0; mMask = '0;
        bErrExp = 1'b0; bCfgQ = C_20;
    endtask

    // Two idle cycles on the dual-lane instance so a new config can take hold
    task automatic idleB(input logic [2:0] c);
        bValid = 1'b0;
        bCfg   = c;
        repeat (2) @(negedge clk);
        bCfgQ = c;
    endtask

    // One always-ready beat on the dual-lane instance
    task automatic stepB(input logic b, input logic [5:0] s, input logic [39:0] d, input logic [39:0] m);
        logic [79:0] ed, em;
        logic        eerr;
        bValid = 1'b1; bReady = 1'b1; bBist = b; bSlot = s; bData = d; bMask = m; bClr = 1'b0;
        refAlign(40, bCfgQ, b, int'(s), {40'b0, d}, {40'b0, m}, ed, em, eerr);
        bErrExp = bErrExp | eerr;
        @(posedge clk);
        #1;
        checkOutput("b valid_o", bValidOut, 1'b1);
        checkOutput("b wrdata_o", bDataOut, ed[39:0]);
        checkOutput("b bitmask_o", bMaskOut, em[39:0]);
        checkOutput("b err_o", bErr, bErrExp);
        @(negedge clk);
    endtask

    // Main sequence: directed corners, random traffic, reset abort, then the wide instance
    initial begin
        logic [2:0] rc;
        applyStimulus(1'b0, 1'b1, C_20, 1'b0, 5'd0, 20'h0, 20'h0, 1'b0);
        bValid = 1'b0; bReady = 1'b1; bCfg = C_20; bBist = 1'b0; bSlot = '0;
        bData = '0; bMask = '0; bClr = 1'b0;
        #2;
        doReset();

        // 5-bit slots, slot 3
        stepCycle(1'b0, 1'b1, C_5, 1'b0, 5'd0, 20'h0, 20'h0, 1'b0);
        stepCycle(1'b1, 1'b1, C_5, 1'b0, 5'd3, 20'h5A5F5, 20'hFFFFF, 1'b0);
        checkOutput("5bit data", wrdataOut, 20'hAD6B5);
        checkOutput("5bit mask", bitmaskOut, 20'hF8000);

        // 10-bit slots, slot 2 is out of range
        stepCycle(1'b0, 1'b1, C_10, 1'b0, 5'd0, 20'h0, 20'h0, 1'b0);
        stepCycle(1'b0, 1'b1, C_10, 1'b0, 5'd0, 20'h0, 20'h0, 1'b0);
        stepCycle(1'b1, 1'b1, C_10, 1'b0, 5'd2, 20'h12345, 20'hFFFFF, 1'b0);
        checkOutput("oor mask", bitmaskOut, 20'h0);
        checkOutput("oor err", errOut, 1'b1);
        stepCycle(1'b0, 1'b1, C_10, 1'b0, 5'd0, 20'h0, 20'h0, 1'b1);
        checkOutput("err clr", errOut, 1'b0);
        stepCycle(1'b1, 1'b1, C_10, 1'b0, 5'd3, 20'h0F0F0, 20'h003FF, 1'b1);
        checkOutput("err set beats clr", errOut, 1'b1);
        stepCycle(1'b0, 1'b1, C_10, 1'b0, 5'd0, 20'h0, 20'h0, 1'b1);

        // Backpressure: stall five cycles, then stream back to back
        for (int k = 0; k < 6; k++)
            stepCycle(1'b1, 1'b0, C_10, 1'b0, 5'(k % 2), 20'(32'h11111 * (k + 1)), 20'h2AB, 1'b0);
        for (int k = 0; k < 4; k++)
            stepCycle(1'b1, 1'b1, C_10, 1'b0, 5'((k + 1) % 2), 20'(32'h0A0A1 * (k + 3)), 20'h155, 1'b0);

        // Config change while the pipe holds a beat
        stepCycle(1'b0, 1'b0, C_2, 1'b0, 5'd0, 20'h0, 20'h0, 1'b0);
        checkOutput("cfg pend set", cfgPend, 1'b1);
        stepCycle(1'b1, 1'b1, C_2, 1'b0, 5'd1, 20'h3C3C3, 20'h00201, 1'b0);
        checkOutput("old width kept", bitmaskOut, 20'h80400);
        stepCycle(1'b0, 1'b1, C_2, 1'b0, 5'd0, 20'h0, 20'h0, 1'b0);
        stepCycle(1'b0, 1'b1, C_2, 1'b0, 5'd0, 20'h0, 20'h0, 1'b0);
        checkOutput("cfg pend clear", cfgPend, 1'b0);
        stepCycle(1'b1, 1'b1, C_2, 1'b0, 5'd5, 20'h00002, 20'h00003, 1'b0);
        checkOutput("new width", bitmaskOut, 20'h00C00);
        checkOutput("new width data", wrdataOut, 20'hAAAAA);

        // Illegal code forwards with an empty mask and flags an error
        stepCycle(1'b0, 1'b1, C_ILL, 1'b0, 5'd0, 20'h0, 20'h0, 1'b1);
        stepCycle(1'b0, 1'b1, C_ILL, 1'b0, 5'd0, 20'h0, 20'h0, 1'b1);
        stepCycle(1'b1, 1'b1, C_ILL, 1'b0, 5'd0, 20'h54321, 20'hFFFFF, 1'b0);
        checkOutput("illegal mask", bitmaskOut, 20'h0);
        checkOutput("illegal err", errOut, 1'b1);

        // Random traffic with random stalls, config changes, BIST and clears
        rc = C_5;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0)
                rc = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            stepCycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rc,
                      $urandom_range(0, 7) == 0, 5'($urandom_range(0, 31)),
                      20'($urandom), 20'($urandom), $urandom_range(0, 15) == 0);
        end

        // Reset while a beat is parked: it must vanish and the config falls back to 20-bit
        stepCycle(1'b0, 1'b1, C_5, 1'b0, 5'd0, 20'h0, 20'h0, 1'b1);
        stepCycle(1'b0, 1'b1, C_5, 1'b0, 5'd0, 20'h0, 20'h0, 1'b1);
        stepCycle(1'b1, 1'b0, C_5, 1'b0, 5'd1, 20'hBEEF1, 20'h003E0, 1'b0);
        doReset();
        stepCycle(1'b1, 1'b1, C_5, 1'b0, 5'd1, 20'h13579, 20'h2468A, 1'b0);
        checkOutput("post-rst passthru mask", bitmaskOut, 20'h2468A);
        stepCycle(1'b0, 1'b1, C_5, 1'b0, 5'd0, 20'h0, 20'h0, 1'b0);

        // Dual-lane instance: 20-bit slot placement and BIST override
        stepB(1'b0, 6'd1, 40'hCAFE012345, 40'h12345FFFFF);
        checkOutput("2lane slot1 mask", bMaskOut, 40'hFFFFF00000);
        stepB(1'b1, 6'd1, 40'hCAFE012345, 40'h12345FFFFF);
        checkOutput("2lane bist mask", bMaskOut, 40'h12345FFFFF);
        for (int c = 0; c < 8; c++) begin
            idleB(3'(c));
            for (int k = 0; k < 6; k++)
                stepB($urandom_range(0, 5) == 0, 6'($urandom_range(0, 63)),
                      {8'($urandom), 32'($urandom)}, {8'($urandom), 32'($urandom)});
        end
        bValid = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
